// File: rtl/regfile_wb_sched_pkg.sv
// regfile_pkg: shared constants and the write-back request type for the
// register-file write-back scheduler.
//   DATA_W   - register width
//   ADDR_W   - register index width
//   NREG     - register count (2**ADDR_W)
//   ZERO_REG - hard-wired zero register; writes to it are discarded
//   wb_req_t - one pending write {rd, data}
package regfile_pkg;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NREG   = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);
  localparam int NPORT  = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_sched_if.sv
// regfile_wb_sched_if: the two write-back requester handshakes
// (port 0 = ALU results, port 1 = load results).
//   master - requester side: drives valid/rd/data, receives ready
//   slave  - scheduler side
interface regfile_wb_sched_if
  import regfile_pkg::*;
();
  logic              wb0_valid, wb0_ready;
  logic [ADDR_W-1:0] wb0_rd;
  logic [DATA_W-1:0] wb0_data;
  logic              wb1_valid, wb1_ready;
  logic [ADDR_W-1:0] wb1_rd;
  logic [DATA_W-1:0] wb1_data;

  modport master (output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
                  input  wb0_ready, wb1_ready);
  modport slave  (input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
                  output wb0_ready, wb1_ready);
endinterface

// File: rtl/regfile_wb_sched_slot.sv
// wb_slot: one-entry holding register for a write-back requester.
//   clk/reset  - clock, async active-high reset
//   in_valid   - requester has a write pending
//   in_req     - incoming {rd, data}
//   grant      - arbiter is draining this slot this cycle
//   ready      - slot accepts this cycle (empty, or draining now)
//   full / req - held entry
module wb_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    in_valid,
  input  wb_req_t in_req,
  input  logic    grant,
  output logic    ready,
  output logic    full,
  output wb_req_t req
);
  // Depends only on slot state and grant, so valid never feeds back into ready.
  assign ready = !full || grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      req  <= '0;
    end else if (in_valid && ready) begin
      full <= 1'b1;
      req  <= in_req;
    end else if (grant) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: shares the register file's single write port between
// two write-back requesters through per-port holding slots and a
// round-robin arbiter, and keeps a per-register busy scoreboard.
//   clk, reset          - clock, async active-high reset
//   wb                  - requester handshakes (slave modport)
//   issue_valid/rd      - issue stage allocates a destination
//   busy                - bit r set while a write to r is outstanding
//   RegWrite/Write_*    - registered register-file write port
module regfile_wb_sched
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_sched_if.slave    wb,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_rd,
  output logic [NREG-1:0]      busy,
  output logic                 RegWrite,
  output logic [ADDR_W-1:0]    Write_register,
  output logic [DATA_W-1:0]    Write_data
);
  logic [NPORT-1:0] in_vld, rdy, full, grant;
  wb_req_t          in_req   [NPORT];
  wb_req_t          slot_req [NPORT];
  wb_req_t          gnt_req;
  logic             rr_ptr;
  logic [NREG-1:0]  busy_nxt;

  assign in_vld    = {wb.wb1_valid, wb.wb0_valid};
  assign in_req[0] = '{rd: wb.wb0_rd, data: wb.wb0_data};
  assign in_req[1] = '{rd: wb.wb1_rd, data: wb.wb1_data};
  assign wb.wb0_ready = rdy[0];
  assign wb.wb1_ready = rdy[1];

  for (genvar p = 0; p < NPORT; p++) begin : g_slot
    wb_slot u_slot (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_vld[p]),
      .in_req   (in_req[p]),
      .grant    (grant[p]),
      .ready    (rdy[p]),
      .full     (full[p]),
      .req      (slot_req[p])
    );
  end

  // rr_ptr only matters when both slots hold a write.
  always_comb begin
    grant = '0;
    case (full)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  assign gnt_req = grant[1] ? slot_req[1] : slot_req[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr         <= 1'b0;
      RegWrite       <= 1'b0;
      Write_register <= '0;
      Write_data     <= '0;
    end else begin
      if (&full) rr_ptr <= ~rr_ptr;
      // Zero-register writes still drain their slot but never reach the file.
      if (|grant && gnt_req.rd != ZERO_REG) begin
        RegWrite       <= 1'b1;
        Write_register <= gnt_req.rd;
        Write_data     <= gnt_req.data;
      end else begin
        RegWrite       <= 1'b0;
      end
    end
  end

  // Clear first, then set: a same-edge reallocation is younger than the write.
  always_comb begin
    busy_nxt = busy;
    if (RegWrite) busy_nxt[Write_register] = 1'b0;
    if (issue_valid && issue_rd != ZERO_REG) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end
endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              issue_valid = 1'b0;
  logic [ADDR_W-1:0] issue_rd = '0;
  logic [NREG-1:0]   busy;
  logic              RegWrite;
  logic [ADDR_W-1:0] Write_register;
  logic [DATA_W-1:0] Write_data;

  regfile_wb_sched_if wb ();

  regfile_wb_sched dut (
    .clk            (clk),
    .reset          (reset),
    .wb             (wb.slave),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .busy           (busy),
    .RegWrite       (RegWrite),
    .Write_register (Write_register),
    .Write_data     (Write_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_no = 0;

  // Transaction-level model: what each requester is holding, whose turn it is
  // on a tie, the last write issued to the file, and the outstanding set.
  bit              m_full [2];
  logic [4:0]      m_rd   [2];
  logic [63:0]     m_data [2];
  bit              m_rr;
  bit              m_we;
  logic [4:0]      m_wr;
  logic [63:0]     m_wd;
  logic [31:0]     m_busy;

  // Writes seen on the DUT port, with the cycle they were observed in.
  int          wl_rd [$];
  logic [63:0] wl_d  [$];
  int          wl_c  [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_no);
    end
  endtask

  task automatic model_clear();
    m_full[0] = 0; m_full[1] = 0;
    m_rd[0] = '0; m_rd[1] = '0; m_data[0] = '0; m_data[1] = '0;
    m_rr = 0; m_we = 0; m_wr = '0; m_wd = '0; m_busy = '0;
  endtask

  // Which requester's held write goes to the file this cycle (-1: none).
  function automatic int winner();
    if (m_full[0] && m_full[1]) return m_rr ? 1 : 0;
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  function automatic bit m_ready(input int p);
    return !m_full[p] || winner() == p;
  endfunction

  task automatic model_edge();
    int g;
    bit rdy [2];
    bit v [2];
    logic [4:0]  r [2];
    logic [63:0] d [2];
    cyc_no++;
    if (reset) begin model_clear(); return; end
    v[0] = wb.wb0_valid; r[0] = wb.wb0_rd; d[0] = wb.wb0_data;
    v[1] = wb.wb1_valid; r[1] = wb.wb1_rd; d[1] = wb.wb1_data;
    g = winner();
    rdy[0] = m_ready(0);
    rdy[1] = m_ready(1);
    if (m_we) m_busy[m_wr] = 1'b0;
    if (issue_valid && issue_rd != 5'd31) m_busy[issue_rd] = 1'b1;
    if (g >= 0 && m_rd[g] != 5'd31) begin
      m_we = 1; m_wr = m_rd[g]; m_wd = m_data[g];
    end else begin
      m_we = 0;
    end
    if (m_full[0] && m_full[1]) m_rr = !m_rr;
    for (int p = 0; p < 2; p++) begin
      if (v[p] && rdy[p]) begin
        m_full[p] = 1; m_rd[p] = r[p]; m_data[p] = d[p];
      end else if (g == p) begin
        m_full[p] = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("RegWrite", RegWrite, m_we);
    chk("Write_register", Write_register, m_wr);
    chk("Write_data", Write_data, m_wd);
    chk("busy", busy, m_busy);
    chk("wb0_ready", wb.wb0_ready, m_ready(0));
    chk("wb1_ready", wb.wb1_ready, m_ready(1));
    if (RegWrite) begin
      wl_rd.push_back(int'(Write_register));
      wl_d.push_back(Write_data);
      wl_c.push_back(cyc_no);
    end
  endtask

  // Drive one cycle of inputs (called at negedge), step the model on the edge,
  // compare at the following negedge.
  task automatic cyc(input bit v0, input int r0, input logic [63:0] d0,
                     input bit v1, input int r1, input logic [63:0] d1,
                     input bit iv = 0, input int ir = 0);
    wb.wb0_valid = v0; wb.wb0_rd = 5'(r0); wb.wb0_data = d0;
    wb.wb1_valid = v1; wb.wb1_rd = 5'(r1); wb.wb1_data = d1;
    issue_valid = iv; issue_rd = 5'(ir);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic clr_log();
    wl_rd.delete(); wl_d.delete(); wl_c.delete();
  endtask

  task automatic chk_log(input string nm, input int i, input int rd, input logic [63:0] d);
    if (i < wl_rd.size()) begin
      chk({nm, "_rd"}, wl_rd[i], rd);
      chk({nm, "_data"}, wl_d[i], d);
    end else begin
      chk({nm, "_present"}, 0, 1);
    end
  endtask

  int h;
  bit saw5;

  initial begin
    wb.wb0_valid = 0; wb.wb0_rd = '0; wb.wb0_data = '0;
    wb.wb1_valid = 0; wb.wb1_rd = '0; wb.wb1_data = '0;
    model_clear();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_Write_register", Write_register, 0);
    chk("rst_Write_data", Write_data, 0);
    chk("rst_busy", busy, 0);
    reset = 0;
    #1;
    chk("rst_ready0", wb.wb0_ready, 1);
    chk("rst_ready1", wb.wb1_ready, 1);
    @(negedge clk);

    // Single stream on port 0, back-to-back
    clr_log();
    cyc(1, 1, 64'h10, 0, 0, 0);
    h = cyc_no;
    cyc(1, 2, 64'h20, 0, 0, 0);
    cyc(1, 3, 64'h30, 0, 0, 0);
    cyc(1, 4, 64'h40, 0, 0, 0);
    idle(3);
    chk("stream_count", wl_rd.size(), 4);
    chk_log("stream0", 0, 1, 64'h10);
    chk_log("stream1", 1, 2, 64'h20);
    chk_log("stream2", 2, 3, 64'h30);
    chk_log("stream3", 3, 4, 64'h40);
    if (wl_c.size() == 4) begin
      chk("stream_latency", wl_c[0], h + 1);
      chk("stream_back2back", wl_c[3] - wl_c[0], 3);
    end

    // Contention: port 0 wins first, then port 1
    clr_log();
    cyc(1, 2, 64'hA, 1, 3, 64'hB);
    chk("cont_ready1_low", wb.wb1_ready, 0);
    idle(1);
    chk("cont_ready1_back", wb.wb1_ready, 1);
    idle(2);
    chk("cont1_count", wl_rd.size(), 2);
    chk_log("cont1_first", 0, 2, 64'hA);
    chk_log("cont1_second", 1, 3, 64'hB);
    if (wl_c.size() == 2) chk("cont1_gap", wl_c[1] - wl_c[0], 1);
    clr_log();
    cyc(1, 2, 64'hA, 1, 3, 64'hB);
    chk("cont2_ready0_low", wb.wb0_ready, 0);
    idle(3);
    chk_log("cont2_first", 0, 3, 64'hB);
    chk_log("cont2_second", 1, 2, 64'hA);

    // Zero register
    clr_log();
    cyc(0, 0, 0, 1, 31, 64'hFFFF);
    cyc(0, 0, 0, 0, 0, 0);
    chk("zero_RegWrite", RegWrite, 0);
    chk("zero_ready1", wb.wb1_ready, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 31);
    chk("zero_busy31", busy[31], 0);
    idle(1);
    chk("zero_no_write", wl_rd.size(), 0);

    // Scoreboard set / clear / same-edge set wins
    cyc(0, 0, 0, 0, 0, 0, 1, 7);
    chk("sb_set", busy[7], 1);
    cyc(1, 7, 64'h77, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("sb_pending", busy[7], 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("sb_cleared", busy[7], 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 7);
    cyc(1, 7, 64'h78, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 7);
    chk("sb_set_wins", busy[7], 1);
    cyc(1, 7, 64'h79, 0, 0, 0);
    idle(2);
    chk("sb_final", busy[7], 0);

    // Stall hold: slot 0 loses and its input changes while ready is low
    clr_log();
    cyc(1, 8, 64'h81, 1, 9, 64'h91);
    cyc(1, 10, 64'hA1, 0, 0, 0);
    chk("stall_ready0_low", wb.wb0_ready, 0);
    cyc(1, 11, 64'hB1, 0, 0, 0);
    cyc(1, 11, 64'hB1, 0, 0, 0);
    idle(3);
    chk("stall_count", wl_rd.size(), 4);
    chk_log("stall0", 0, 8, 64'h81);
    chk_log("stall1", 1, 9, 64'h91);
    chk_log("stall2", 2, 10, 64'hA1);
    chk_log("stall3", 3, 11, 64'hB1);

    // Reset mid-operation with rd=5 held in slot 0
    clr_log();
    cyc(0, 0, 0, 0, 0, 0, 1, 5);
    cyc(1, 5, 64'h55, 0, 0, 0);
    wb.wb0_valid = 0;
    reset = 1;
    #1;
    model_clear();
    chk("midrst_RegWrite", RegWrite, 0);
    chk("midrst_busy", busy, 0);
    cyc(0, 0, 0, 0, 0, 0);
    reset = 0;
    #1;
    chk("midrst_ready0", wb.wb0_ready, 1);
    chk("midrst_ready1", wb.wb1_ready, 1);
    @(negedge clk);
    idle(3);
    saw5 = 0;
    foreach (wl_rd[i]) if (wl_rd[i] == 5) saw5 = 1;
    chk("midrst_no_rd5", saw5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-back scheduler that shares the 64-bit × 32-entry register file's single write port between two write-back requesters: port 0 for ALU results and port 1 for load results. Each requester gets a one-entry holding slot and a valid/ready handshake. A round-robin arbiter drives the register file's RegWrite/Write_register/Write_data from a registered output stage. A per-register busy scoreboard lets the issue stage detect outstanding writes.

## Interface
Parameters:
- DATA_W, 64, write data width
- ADDR_W, 5, register index width
- NREG, 32, number of registers (2**ADDR_W)
- ZERO_REG, 31, hard-wired zero register; writes to it are discarded

Ports:
- clk  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- wb0_valid / wb1_valid  in  1  requester has a write pending
- wb0_ready / wb1_ready  out  1  slot can accept this cycle
- wb0_rd / wb1_rd  in  ADDR_W  destination register
- wb0_data / wb1_data  in  DATA_W  write value
- issue_valid  in  1  issue stage allocates a destination this cycle
- issue_rd  in  ADDR_W  allocated destination
- busy  out  NREG  bit r = write to r outstanding
- RegWrite  out  1  register-file write enable (registered)
- Write_register  out  ADDR_W  register-file write index (registered)
- Write_data  out  DATA_W  register-file write value (registered)

## Operation
- Handshake: a transfer happens on a posedge with wbN_valid && wbN_ready. rd/data are captured into slot N. valid may drop only after a transfer.
- wbN_ready = !slotN_full || slotN_granted (same-cycle drain and refill). It is combinational from slot state and the grant only, never from wbN_valid.
- Arbitration (combinational, each cycle over full slots):
  - one slot full → grant it;
  - both full → grant the slot pointed to by rr_ptr, then set rr_ptr to the other slot.
  - rr_ptr changes only on a contested grant.
- Output stage, on each posedge:
  - if a grant exists and the granted rd != ZERO_REG: RegWrite=1, Write_register=rd, Write_data=data;
  - otherwise RegWrite=0, and Write_register/Write_data hold their previous values.
  - A granted slot empties whether or not its rd is ZERO_REG.
- Scoreboard, on each posedge:
  - issue_valid && issue_rd != ZERO_REG sets busy[issue_rd];
  - RegWrite=1 clears busy[Write_register] (the write lands in the register file on that same edge);
  - set and clear of the same index on one edge → set wins, because the new allocation is younger.
  - busy[ZERO_REG] is always 0.
- Reset values:
  - RegWrite=0, Write_register=0, Write_data=0, busy=0;
  - both slots empty, rr_ptr=0 (port 0 first);
  - wb0_ready=wb1_ready=1 while reset is deasserted and both slots are empty.
- Reset mid-operation: held and in-flight writes are dropped, and busy bits are cleared. No register-file write occurs after reset asserts.

## Timing
- Uncontested latency: handshake at edge E → RegWrite high during cycle E+1..E+2 → register file written at edge E+2.
- Contested: the loser is written exactly one cycle later. Its ready stays low until its slot drains.
- Throughput: one write per cycle total. A single requester can stream back-to-back at one write per cycle.
- busy is registered. An issue at edge E is visible from E onward. The clear is visible after the write edge.
- No combinational path from wb*_valid to wb*_ready, or from any input to RegWrite/Write_*.

## Structure
- Shared package regfile_pkg: DATA_W, ADDR_W, NREG, ZERO_REG constants; a typedef for the write-back request {rd, data}.
- Sub-module wb_slot: a one-entry holding register with full flag, valid/ready logic and a grant-drain input. It is instantiated twice.
- The top level holds the arbiter, rr_ptr, output register and scoreboard.

## Test plan
- Reset values: assert reset mid-stream, with slot 0 holding rd=5 → RegWrite=0 next cycle, busy=0, both ready=1 after release, register 5 never written.
- Single stream: wb0 sends rd=1..4, data=0x10..0x40, back-to-back → RegWrite high 4 consecutive cycles, writes in order, starting 1 cycle after the first handshake; wb0_ready stays 1.
- Contention: both valid on the same edge (rd=2/0xA, rd=3/0xB), rr_ptr=0 → rd=2 written first, rd=3 next cycle, wb1_ready low for 1 cycle. Repeat → rd from port 1 goes first.
- Zero register: wb1 sends rd=31, data=0xFFFF → handshake completes, RegWrite stays 0, busy[31]=0, slot frees next cycle.
- Scoreboard: issue rd=7 → busy[7]=1. A write to rd=7 clears it on the write edge. An issue of rd=7 on that same edge keeps busy[7]=1.
- Stall hold: wb0 valid while slot 0 is full and losing arbitration → rd/data held stable and the value written is the original one, not the newer input.
